rgb2gray_stream: RTL and testbench
==================================

# rgb2gray_stream

Parametrised, back-pressurable RGB-to-grayscale converter for the image pipeline. It replaces the fixed 8-bit, valid-only converter with a valid/ready streaming stage that has:
- configurable pixel and coefficient widths,
- run-time coefficients latched per frame,
- start-of-frame and end-of-line sideband pass-through,
- frame and pixel status counters.

It sits between the pixel source (PPM reader / sensor front end) and the gray sink (PGM writer / downstream filters).

## Interface
- DATA_W, 8: bits per colour channel and per gray output.
- COEF_W, 8: coefficient width; also the right-shift applied to the weighted sum.
- CNT_W, 24: width of the pixel counter.
- DEF_R / DEF_G / DEF_B, 77 / 150 / 29: coefficients loaded at reset.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  converter can accept a beat.
- in_r, in_g, in_b  in  DATA_W each  colour channels.
- in_sof  in  1  first pixel of frame.
- in_eol  in  1  last pixel of line.
- cfg_coef_r, cfg_coef_g, cfg_coef_b  in  COEF_W each  pending coefficients.
- out_valid  out  1  gray beat valid.
- out_ready  in  1  sink accepts beat.
- out_gray  out  DATA_W  gray value.
- out_sof, out_eol  out  1 each  sideband, aligned with out_gray.
- frame_cnt  out  16  count of frames emitted (sof beats transferred at output).
- pix_cnt  out  CNT_W  beats emitted in current frame.

## Operation
- Transfer occurs on a port when valid and ready are both high at a rising edge.
- Active coefficients (act_r/g/b):
  - Set to DEF_* on reset.
  - Replaced by cfg_coef_* when an input beat with in_sof=1 is accepted; that beat and all later beats use the new values.
  - cfg_coef_* changes at any other time have no effect.
- Pipeline stage 0 (S0): register inputs, sideband and the coefficients to be applied.
- Pipeline stage 1 (S1): three products, each DATA_W+COEF_W bits, registered.
- Pipeline stage 2 (S2): sum the products, width DATA_W+COEF_W+2. Optionally add the rounding constant (see Configuration). Shift right by COEF_W. If the result exceeds 2^DATA_W−1, saturate to 2^DATA_W−1. Register the result to out_gray.
- Flow control:
  - Each stage holds its own valid bit.
  - stage_ready[i] = !valid[i] || stage_ready[i+1], with stage_ready[3] = out_ready.
  - in_ready = stage_ready[0].
  - A stalled stage holds its data unchanged; no beat is dropped or duplicated.
- Counters (update only on an output transfer):
  - Beat with out_sof=1: pix_cnt←1 and frame_cnt←frame_cnt+1.
  - Any other beat: pix_cnt←pix_cnt+1.
  - Both counters wrap modulo 2^width.
- out_sof and out_eol pass through unmodified. A beat with both set is legal.

## Timing
- Reset values: out_valid=0, out_gray=0, out_sof=0, out_eol=0, frame_cnt=0, pix_cnt=0, all stage valids 0, in_ready=1 during and after reset.
- Latency: an accepted beat appears on out_gray exactly 3 cycles after acceptance when out_ready stays high.
- Throughput: one beat per cycle with no stalls.
- Outputs are stable while out_valid=1 and out_ready=0.
- When all stages are full and out_ready=0, in_ready=0 in the same cycle.
- Rising out_ready while the pipeline is full: in_ready rises combinationally in that cycle and one beat moves per stage.
- Reset mid-stream: all in-flight beats are discarded, counters clear, coefficients return to DEF_*. The first post-reset beat is treated normally even without sof.

## Configuration
- RGB2GRAY_ROUND_EN:
  - Defined: add 2^(COEF_W−1) to the sum before shifting (round half up).
  - Undefined: truncate.
- Saturation, latency and the handshake are identical in both builds.

## Test plan
- Defaults, no macro, out_ready=1; inputs (255,0,0), (0,255,0), (0,0,255), (255,255,255), (0,0,0) → 76, 149, 28, 255, 0. Each output appears 3 cycles after its input.
- Same stimulus with RGB2GRAY_ROUND_EN → 77, 149, 29, 255, 0.
- Stream 64 random pixels back-to-back; out_ready toggled pseudo-randomly at 50% → all 64 outputs match the reference model, in order. None are lost or duplicated. Outputs hold stable while stalled.
- Frame 1 with default coefficients, then frame 2: in_sof beat with cfg=(200,200,200) and pixel (255,255,255) → saturates to 255. A later pixel (1,1,1) → 600>>8 = 2. Frame 1 pixels are unaffected by cfg changes made mid-frame.
- Two frames of 4×3 pixels with eol every 4th beat → out_eol on beats 4, 8, 12. pix_cnt reads 12 at the end of each frame. frame_cnt reads 2.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 next cycle, counters 0, no stale beat emitted. Next accepted beat (10,20,30) → gray 18 after 3 cycles.

Source files
------------

// File: rtl/rgb2gray_stream_if.sv
// Stream bundle for rgb2gray_stream: RGB pixel beats in, gray beats out, each with valid/ready.
// master = surrounding pipeline (pixel source and gray sink), slave = the converter.
interface rgb2gray_stream_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_b;
  logic              in_sof;
  logic              in_eol;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_gray;
  logic              out_sof;
  logic              out_eol;

  modport master (
    output in_valid, in_r, in_g, in_b, in_sof, in_eol, out_ready,
    input  in_ready, out_valid, out_gray, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_sof, in_eol, out_ready,
    output in_ready, out_valid, out_gray, out_sof, out_eol
  );
endinterface

// File: rtl/rgb2gray_stream.sv
// RGB->gray valid/ready stage: 3 register stages (latency 3, one beat per cycle); a stage stalls only when full and blocked.
// Optional macro RGB2GRAY_ROUND_EN: round half up before the shift instead of truncating.
module rgb2gray_stream #(
  parameter int          DATA_W = 8,
  parameter int          COEF_W = 8,
  parameter int          CNT_W  = 24,
  parameter int unsigned DEF_R  = 77,
  parameter int unsigned DEF_G  = 150,
  parameter int unsigned DEF_B  = 29
) (
  input  logic              clk,
  input  logic              rst,
  rgb2gray_stream_if.slave  s,
  input  logic [COEF_W-1:0] cfg_coef_r,
  input  logic [COEF_W-1:0] cfg_coef_g,
  input  logic [COEF_W-1:0] cfg_coef_b,
  output logic [15:0]       frame_cnt,
  output logic [CNT_W-1:0]  pix_cnt
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
    logic [COEF_W-1:0] cr;
    logic [COEF_W-1:0] cg;
    logic [COEF_W-1:0] cb;
    logic              sof;
    logic              eol;
  } s0_t;

  typedef struct packed {
    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] pg;
    logic [PROD_W-1:0] pb;
    logic              sof;
    logic              eol;
  } s1_t;

  logic              v0, v1, v2;
  logic              rdy0, rdy1, rdy2;
  logic              in_fire, out_fire;
  logic [COEF_W-1:0] act_r, act_g, act_b;
  s0_t               s0_q, s0_d;
  s1_t               s1_q, s1_d;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W+1:0] shifted;
  logic [DATA_W-1:0] gray_nxt;

  assign rdy2       = !v2 || s.out_ready;
  assign rdy1       = !v1 || rdy2;
  assign rdy0       = !v0 || rdy1;
  assign s.in_ready = rdy0;
  assign s.out_valid = v2;
  assign in_fire    = s.in_valid && rdy0;
  assign out_fire   = v2 && s.out_ready;

  always_comb begin
    s0_d     = '0;
    s0_d.r   = s.in_r;
    s0_d.g   = s.in_g;
    s0_d.b   = s.in_b;
    // A sof beat already uses the pending coefficients it is about to latch.
    s0_d.cr  = s.in_sof ? cfg_coef_r : act_r;
    s0_d.cg  = s.in_sof ? cfg_coef_g : act_g;
    s0_d.cb  = s.in_sof ? cfg_coef_b : act_b;
    s0_d.sof = s.in_sof;
    s0_d.eol = s.in_eol;

    s1_d     = '0;
    s1_d.pr  = PROD_W'(s0_q.r) * PROD_W'(s0_q.cr);
    s1_d.pg  = PROD_W'(s0_q.g) * PROD_W'(s0_q.cg);
    s1_d.pb  = PROD_W'(s0_q.b) * PROD_W'(s0_q.cb);
    s1_d.sof = s0_q.sof;
    s1_d.eol = s0_q.eol;

    sum = SUM_W'(s1_q.pr) + SUM_W'(s1_q.pg) + SUM_W'(s1_q.pb);
`ifdef RGB2GRAY_ROUND_EN
    sum = sum + (SUM_W'(1) << (COEF_W - 1));
`endif
    shifted  = sum[SUM_W-1:COEF_W];
    gray_nxt = (|shifted[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
      s.out_gray <= '0;
      s.out_sof  <= 1'b0;
      s.out_eol  <= 1'b0;
      act_r      <= COEF_W'(DEF_R);
      act_g      <= COEF_W'(DEF_G);
      act_b      <= COEF_W'(DEF_B);
      frame_cnt  <= '0;
      pix_cnt    <= '0;
    end else begin
      if (rdy0) begin
        v0 <= s.in_valid;
        if (s.in_valid) s0_q <= s0_d;
      end
      if (in_fire && s.in_sof) begin
        act_r <= cfg_coef_r;
        act_g <= cfg_coef_g;
        act_b <= cfg_coef_b;
      end
      if (rdy1) begin
        v1 <= v0;
        if (v0) s1_q <= s1_d;
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          s.out_gray <= gray_nxt;
          s.out_sof  <= s1_q.sof;
          s.out_eol  <= s1_q.eol;
        end
      end
      if (out_fire) begin
        if (s.out_sof) begin
          pix_cnt   <= CNT_W'(1);
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream with 8-bit data, default coefficients 77/150/29.
`timescale 1ns/1ps
module tb_rgb2gray_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_r, cfg_g, cfg_b;
  logic [15:0] frame_cnt;
  logic [23:0] pix_cnt;

  rgb2gray_stream_if #(.DATA_W(8)) bus ();

  rgb2gray_stream dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .cfg_coef_r (cfg_r),
    .cfg_coef_g (cfg_g),
    .cfg_coef_b (cfg_b),
    .frame_cnt  (frame_cnt),
    .pix_cnt    (pix_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray_ref(input int r, input int g, input int b,
                                  input int cr, input int cg, input int cb);
    int sum;
    sum = r * cr + g * cg + b * cb;
`ifdef RGB2GRAY_ROUND_EN
    sum += 128;
`endif
    sum = sum >> 8;
    return (sum > 255) ? 255 : sum;
  endfunction

  typedef struct {
    logic [7:0]  gray;
    logic        sof;
    logic        eol;
    logic [23:0] pix_before;
  } cap_t;

  cap_t got[$];
  int   exp_q[$];

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got.push_back('{bus.out_gray, bus.out_sof, bus.out_eol, pix_cnt});
  end

  bit         stab_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_gray;
  always @(negedge clk) begin
    if (stab_en && prev_stall) begin
      chk("stall_hold_valid", bus.out_valid, 1);
      chk("stall_hold_gray", bus.out_gray, prev_gray);
    end
    prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    prev_gray  = bus.out_gray;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic sof, input logic eol);
    bus.in_valid = 1'b1;
    bus.in_r     = r;
    bus.in_g     = g;
    bus.in_b     = b;
    bus.in_sof   = sof;
    bus.in_eol   = eol;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof, eol;
    logic [7:0] cr, cg, cb;
    logic [7:0] exp_t, exp_rd;
  } vec_t;

  vec_t vt[9];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit drv_done;
    logic acc;
    int   exp_g;

    // r, g, b, sof, eol, cfg r/g/b, expected truncated, expected rounded
    vt[0] = '{255, 0,   0,   0, 0, 77,  150, 29,  76,  77};
    vt[1] = '{0,   255, 0,   0, 0, 77,  150, 29,  149, 149};
    vt[2] = '{0,   0,   255, 0, 0, 77,  150, 29,  28,  29};
    vt[3] = '{255, 255, 255, 0, 0, 77,  150, 29,  255, 255};
    vt[4] = '{0,   0,   0,   0, 1, 77,  150, 29,  0,   0};
    vt[5] = '{100, 100, 100, 1, 0, 77,  150, 29,  100, 100};
    vt[6] = '{255, 0,   0,   0, 0, 200, 200, 200, 76,  77};
    vt[7] = '{255, 255, 255, 1, 1, 200, 200, 200, 255, 255};
    vt[8] = '{1,   1,   1,   0, 0, 0,   0,   0,   2,   2};

    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_g      = '0;
    bus.in_b      = '0;
    bus.in_sof    = 1'b0;
    bus.in_eol    = 1'b0;
    bus.out_ready = 1'b1;
    cfg_r = 8'd77;
    cfg_g = 8'd150;
    cfg_b = 8'd29;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_gray", bus.out_gray, 0);
    chk("rst_out_sof", bus.out_sof, 0);
    chk("rst_out_eol", bus.out_eol, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Vector table: one beat at a time, exact latency and sideband check
    for (int i = 0; i < 9; i++) begin
      cfg_r = vt[i].cr;
      cfg_g = vt[i].cg;
      cfg_b = vt[i].cb;
      drive(vt[i].r, vt[i].g, vt[i].b, vt[i].sof, vt[i].eol);
      @(negedge clk);
      chk("tbl_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("tbl_lat_c1_valid", bus.out_valid, 0);
      tick();
      chk("tbl_lat_c2_valid", bus.out_valid, 0);
      tick();
      chk("tbl_lat_c3_valid", bus.out_valid, 1);
`ifdef RGB2GRAY_ROUND_EN
      chk("tbl_gray", bus.out_gray, vt[i].exp_rd);
`else
      chk("tbl_gray", bus.out_gray, vt[i].exp_t);
`endif
      chk("tbl_sof", bus.out_sof, vt[i].sof);
      chk("tbl_eol", bus.out_eol, vt[i].eol);
      tick();
    end
    chk("tbl_frame_cnt", frame_cnt, 2);
    chk("tbl_pix_cnt", pix_cnt, 2);

    // Pseudo-random stream with random output backpressure
    do_reset();
    got.delete();
    exp_q.delete();
    stab_en  = 1'b1;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          logic [7:0] r, g, b;
          int guard;
          r = 8'($urandom_range(0, 255));
          g = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          drive(r, g, b, 1'b0, 1'b0);
          exp_q.push_back(gray_ref(r, g, b, 77, 150, 29));
          guard = 0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            guard++;
          end while (acc !== 1'b1 && guard < 200);
          chk("stream_accept", acc, 1);
        end
        bus.in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 500 && got.size() < 64; k++) tick();
    for (int k = 0; k < 5; k++) tick();
    stab_en = 1'b0;
    chk("stream_count", got.size(), 64);
    for (int i = 0; i < 64 && i < got.size(); i++)
      chk("stream_data", got[i].gray, exp_q[i]);

    // Fill all stages with the sink blocked, then release
    got.delete();
    bus.out_ready = 1'b0;
    drive(255, 0, 0, 1'b0, 1'b0);
    @(negedge clk); chk("fill_rdy0", bus.in_ready, 1); tick();
    drive(0, 255, 0, 1'b0, 1'b0);
    @(negedge clk); chk("fill_rdy1", bus.in_ready, 1); tick();
    drive(0, 0, 255, 1'b0, 1'b0);
    @(negedge clk); chk("fill_rdy2", bus.in_ready, 1); tick();
    drive(10, 20, 30, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_out_gray", bus.out_gray, gray_ref(255, 0, 0, 77, 150, 29));
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready_comb", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("release_advance_valid", bus.out_valid, 1);
    chk("release_advance_gray", bus.out_gray, gray_ref(0, 255, 0, 77, 150, 29));
    for (int k = 0; k < 6; k++) tick();
    chk("release_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("release_beat0", got[0].gray, gray_ref(255, 0, 0, 77, 150, 29));
      chk("release_beat1", got[1].gray, gray_ref(0, 255, 0, 77, 150, 29));
      chk("release_beat2", got[2].gray, gray_ref(0, 0, 255, 77, 150, 29));
      chk("release_beat3", got[3].gray, gray_ref(10, 20, 30, 77, 150, 29));
    end

    // Two 4x3 frames back to back
    do_reset();
    got.delete();
    cfg_r = 8'd77;
    cfg_g = 8'd150;
    cfg_b = 8'd29;
    for (int i = 0; i < 24; i++) begin
      drive(8'(i * 10), 8'(i * 5), 8'(255 - i * 10), 1'((i % 12) == 0), 1'((i % 4) == 3));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("frame_beats", got.size(), 24);
    for (int i = 0; i < 24 && i < got.size(); i++) begin
      exp_g = gray_ref(i * 10, i * 5, 255 - i * 10, 77, 150, 29);
      chk("frame_gray", got[i].gray, exp_g);
      chk("frame_eol", got[i].eol, ((i % 4) == 3) ? 1 : 0);
      chk("frame_sof", got[i].sof, ((i % 12) == 0) ? 1 : 0);
    end
    if (got.size() > 12) chk("frame1_end_pix_cnt", got[12].pix_before, 12);
    chk("frame2_end_pix_cnt", pix_cnt, 12);
    chk("frame_cnt_two", frame_cnt, 2);

    // Reset with three beats in flight
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(255, 255, 255, 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("inflight_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_pix_cnt", pix_cnt, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_no_stale", got.size(), 0);
    drive(10, 20, 30, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("midrst_lat_c1", bus.out_valid, 0);
    tick();
    chk("midrst_lat_c2", bus.out_valid, 0);
    tick();
    chk("midrst_lat_c3", bus.out_valid, 1);
    chk("midrst_gray", bus.out_gray, 18);
    tick();
    chk("midrst_pix_after", pix_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
